// File: rtl/dkong_wram_arb.sv
// Port A arbiter for the sprite work RAM. The Z80 has priority and the hiscore
// engine takes idle cycles. A starved hiscore request steals one CPU phase by
// pulling WAIT_n low.
module dkong_wram_arb #(
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_CLK_EN_P,
    input  logic [9:0] I_CPU_A,
    input  logic [7:0] I_CPU_D,
    input  logic       I_CPU_CS_n,
    input  logic       I_CPU_RD_n,
    input  logic       I_CPU_WR_n,
    output logic [7:0] O_CPU_D,
    output logic       O_CPU_WAIT_n,
    input  logic       I_HS_REQ,
    input  logic       I_HS_WE,
    input  logic [9:0] I_HS_A,
    input  logic [7:0] I_HS_D,
    output logic       O_HS_ACK,
    output logic [7:0] O_HS_D,
    output logic [9:0] O_RAM_A,
    output logic [7:0] O_RAM_D,
    output logic       O_RAM_CE,
    output logic       O_RAM_WE,
    input  logic [7:0] I_RAM_Q
);

    typedef enum logic [1:0] {StIdle, StSteal, StHsIssue, StHsAck} state_t;

    localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic [7:0] starve_inc;
    logic       stolen_q, stolen_d;   // current HS slot was forced via WAIT_n
    logic       hs_we_q, hs_we_d;     // direction of the access being acknowledged
    logic       rd_own_q, rd_own_d;   // CPU owned the port for a read last clock
    logic       cpu_act;
    logic       hs_own;

    assign cpu_act    = ~I_CPU_CS_n & (~I_CPU_RD_n | ~I_CPU_WR_n);
    assign hs_own     = (state_q == StHsIssue);
    assign starve_inc = (starve_cnt_q < Limit) ? starve_cnt_q + 8'd1 : starve_cnt_q;

    // Next-state logic for the hiscore slot scheduler.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        stolen_d     = stolen_q;
        hs_we_d      = hs_we_q;
        unique case (state_q)
            StIdle: begin
                if (!I_HS_REQ) begin
                    starve_cnt_d = 8'd0;
                end else if (!cpu_act) begin
                    state_d  = StHsIssue;
                    stolen_d = 1'b0;
                end else begin
                    starve_cnt_d = starve_inc;
                    if (starve_inc == Limit) begin
                        state_d = StSteal;
                    end
                end
            end
            StSteal: begin
                // A dropped request is abandoned even if the phase enable is here.
                if (!I_HS_REQ) begin
                    state_d      = StIdle;
                    starve_cnt_d = 8'd0;
                end else if (I_CLK_EN_P) begin
                    state_d  = StHsIssue;
                    stolen_d = 1'b1;
                end
            end
            StHsIssue: begin
                state_d = StHsAck;
                hs_we_d = I_HS_WE;
            end
            StHsAck: begin
                state_d      = StIdle;
                starve_cnt_d = 8'd0;
                stolen_d     = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // CPU read ownership for the 1-clock RAM read latency.
    always_comb begin
        rd_own_d = ~hs_own & cpu_act & I_CPU_WR_n;
    end

    // State registers with synchronous reset.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q      <= StIdle;
            starve_cnt_q <= 8'd0;
            stolen_q     <= 1'b0;
            hs_we_q      <= 1'b0;
            rd_own_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            stolen_q     <= stolen_d;
            hs_we_q      <= hs_we_d;
            rd_own_q     <= rd_own_d;
        end
    end

    // Owner mux and bus-side outputs.
    always_comb begin
        O_RAM_A  = I_CPU_A;
        O_RAM_D  = I_CPU_D;
        O_RAM_CE = cpu_act;
        O_RAM_WE = cpu_act & ~I_CPU_WR_n;
        if (hs_own) begin
            O_RAM_A  = I_HS_A;
            O_RAM_D  = I_HS_D;
            O_RAM_CE = 1'b1;
            O_RAM_WE = I_HS_WE;
        end
        O_CPU_WAIT_n = ~((state_q == StSteal) | (hs_own & stolen_q));
        O_HS_ACK     = (state_q == StHsAck);
        O_HS_D       = (O_HS_ACK & ~hs_we_q) ? I_RAM_Q : 8'h00;
        O_CPU_D      = (rd_own_q & cpu_act & ~I_CPU_RD_n) ? I_RAM_Q : 8'h00;
    end

endmodule

// File: tb/tb_dkong_wram_arb.sv
// Bench for dkong_wram_arb: directed literal checks plus randomized traffic
// compared every clock against a behavioural model with its own RAM image.
module tb_dkong_wram_arb;

    localparam int unsigned LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic [9:0] cpu_a = 10'd0;
    logic [7:0] cpu_d = 8'd0;
    logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic       hs_req = 1'b0, hs_we = 1'b0;
    logic [9:0] hs_a = 10'd0;
    logic [7:0] hs_d_in = 8'd0;

    logic [7:0] cpu_q, hs_q, ram_dout, ram_q;
    logic [9:0] ram_a;
    logic       wait_n, hs_ack, ram_ce, ram_we;

    logic [7:0] mem [1024];
    logic [7:0] shadow [1024];
    bit         ram_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    dkong_wram_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_CLK_EN_P(clk_en),
        .I_CPU_A(cpu_a), .I_CPU_D(cpu_d), .I_CPU_CS_n(cs_n),
        .I_CPU_RD_n(rd_n), .I_CPU_WR_n(wr_n),
        .O_CPU_D(cpu_q), .O_CPU_WAIT_n(wait_n),
        .I_HS_REQ(hs_req), .I_HS_WE(hs_we), .I_HS_A(hs_a), .I_HS_D(hs_d_in),
        .O_HS_ACK(hs_ack), .O_HS_D(hs_q),
        .O_RAM_A(ram_a), .O_RAM_D(ram_dout), .O_RAM_CE(ram_ce), .O_RAM_WE(ram_we),
        .I_RAM_Q(ram_q)
    );

    always #5 clk = ~clk;

    // Registered single-port RAM, image loaded on the first (reset) edge.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 11);
            ram_q     <= 8'h00;
            ram_ready <= 1'b1;
        end else if (ram_ce) begin
            if (ram_we) mem[ram_a] <= ram_dout;
            ram_q <= mem[ram_a];
        end
    end

    // Phase enable: one clock in four.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            clk_en = (cyc % 4 == 1);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state
    bit         m_issue = 0, m_ack = 0, m_steal = 0, m_stolen = 0, m_ack_we = 0;
    bit         m_rd_pend = 0, nx_rd_pend;
    int         m_cnt = 0;
    logic [7:0] m_hs_val = 0, m_rd_val = 0, nx_rd_val;
    bit         act, e_ce, e_we, e_wait, e_ack;
    logic [9:0] e_a;
    logic [7:0] e_d, e_hsd, e_cpud;

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = 8'(i * 37 + 11);
        forever begin
            @(negedge clk);
            act = !cs_n && (!rd_n || !wr_n);
            if (m_issue) begin
                e_a = hs_a; e_d = hs_d_in; e_ce = 1'b1; e_we = hs_we;
            end else begin
                e_a = cpu_a; e_d = cpu_d; e_ce = act; e_we = act && !wr_n;
            end
            e_wait = !(m_steal || (m_issue && m_stolen));
            e_ack  = m_ack;
            e_hsd  = (m_ack && !m_ack_we) ? m_hs_val : 8'h00;
            e_cpud = (m_rd_pend && act && !rd_n) ? m_rd_val : 8'h00;
            if (chk_en) begin
                chk("ram_a", 16'(ram_a), 16'(e_a));
                chk("ram_d", 16'(ram_dout), 16'(e_d));
                chk("ram_ce", 16'(ram_ce), 16'(e_ce));
                chk("ram_we", 16'(ram_we), 16'(e_we));
                chk("wait_n", 16'(wait_n), 16'(e_wait));
                chk("hs_ack", 16'(hs_ack), 16'(e_ack));
                chk("hs_d", 16'(hs_q), 16'(e_hsd));
                chk("cpu_d", 16'(cpu_q), 16'(e_cpud));
            end
            nx_rd_pend = !m_issue && act && wr_n;
            nx_rd_val  = shadow[cpu_a];
            if (m_issue) begin
                m_hs_val = shadow[hs_a];
                m_ack_we = hs_we;
            end
            if (e_ce && e_we) shadow[e_a] = e_d;
            if (m_issue) begin
                m_issue = 0; m_ack = 1;
            end else if (m_ack) begin
                m_ack = 0; m_cnt = 0; m_stolen = 0;
            end else if (m_steal) begin
                if (!hs_req) begin
                    m_steal = 0; m_cnt = 0;
                end else if (clk_en) begin
                    m_steal = 0; m_issue = 1; m_stolen = 1;
                end
            end else if (!hs_req) begin
                m_cnt = 0;
            end else if (!act) begin
                m_issue = 1; m_stolen = 0;
            end else begin
                if (m_cnt < int'(LIMIT)) m_cnt = m_cnt + 1;
                if (m_cnt == int'(LIMIT)) m_steal = 1;
            end
            m_rd_pend = nx_rd_pend;
            m_rd_val  = nx_rd_val;
            if (rst) begin
                m_issue = 0; m_ack = 0; m_steal = 0; m_stolen = 0;
                m_cnt = 0; m_rd_pend = 0;
            end
        end
    end

    // One uncontended hiscore access from IDLE with the CPU idle.
    task automatic hs_op(input bit we, input logic [9:0] a, input logic [7:0] d,
                         input logic [7:0] exp_q);
        hs_req = 1'b1; hs_we = we; hs_a = a; hs_d_in = d;
        tick();
        chk("op_issue_ce", 16'(ram_ce), 16'd1);
        chk("op_issue_ack", 16'(hs_ack), 16'd0);
        tick();
        chk("op_ack", 16'(hs_ack), 16'd1);
        chk("op_hs_d", 16'(hs_q), we ? 16'd0 : 16'(exp_q));
        hs_req = 1'b0;
        tick();
    endtask

    bit found, prev_en;
    int pct;

    initial begin
        // Reset held for two clocks with a pending request
        rst = 1'b1; hs_req = 1'b1; hs_we = 1'b0; hs_a = 10'h155;
        tick();
        chk_en = 1'b1;
        chk("rst_ack", 16'(hs_ack), 16'd0);
        chk("rst_wait", 16'(wait_n), 16'd1);
        chk("rst_ce", 16'(ram_ce), 16'd0);
        tick();
        chk("rst_ack2", 16'(hs_ack), 16'd0);
        chk("rst_ce2", 16'(ram_ce), 16'd0);
        chk("rst_cpu_d", 16'(cpu_q), 16'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ack1", 16'(hs_ack), 16'd0);
        tick();
        chk("post_rst_ack2", 16'(hs_ack), 16'd1);
        hs_req = 1'b0;
        tick();

        // Idle write then read-back, then seed 0x010 for the CPU
        hs_op(1'b1, 10'h155, 8'hA5, 8'h00);
        hs_op(1'b0, 10'h155, 8'h00, 8'hA5);
        hs_op(1'b1, 10'h010, 8'h3C, 8'h00);

        // Starvation: CPU reads 0x010 continuously
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; cpu_a = 10'h010;
        tick();
        tick();
        chk("cpu_rd_010", 16'(cpu_q), 16'h3C);
        hs_req = 1'b1; hs_we = 1'b0; hs_a = 10'h155;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("starve_wait", 16'(wait_n), (k < 4) ? 16'd1 : 16'd0);
        end
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            prev_en = clk_en;
            tick();
            if (ram_ce && ram_a == 10'h155) begin
                found = 1'b1;
                break;
            end
            chk("steal_wait", 16'(wait_n), 16'd0);
        end
        chk("steal_found", 16'(found), 16'd1);
        chk("steal_en", 16'(prev_en), 16'd1);
        chk("steal_issue_wait", 16'(wait_n), 16'd0);
        tick();
        chk("steal_ack", 16'(hs_ack), 16'd1);
        chk("steal_ack_wait", 16'(wait_n), 16'd1);
        chk("steal_hs_d", 16'(hs_q), 16'hA5);
        hs_req = 1'b0;
        tick();
        chk("steal_cpu_d", 16'(cpu_q), 16'h3C);

        // Abandoned request in IDLE, then in STEAL
        hs_req = 1'b1;
        tick();
        tick();
        hs_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("aband_ack", 16'(hs_ack), 16'd0);
            chk("aband_a", 16'(ram_a), 16'h010);
        end
        hs_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("aband_restart_wait", 16'(wait_n), (k < 4) ? 16'd1 : 16'd0);
        end
        hs_req = 1'b0;
        tick();
        chk("aband_steal_wait", 16'(wait_n), 16'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("aband_steal_ack", 16'(hs_ack), 16'd0);
            chk("aband_steal_a", 16'(ram_a), 16'h010);
        end

        // Back-to-back on an idle bus
        cs_n = 1'b1; rd_n = 1'b1;
        tick();
        hs_req = 1'b1; hs_we = 1'b0; hs_a = 10'h155;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("b2b_ack", 16'(hs_ack), (k == 2 || k == 5 || k == 8) ? 16'd1 : 16'd0);
        end
        hs_req = 1'b0;
        tick();
        tick();

        // Randomized traffic with varying CPU load and occasional resets
        for (int i = 0; i < 3000; i++) begin
            case (i / 500)
                0: pct = 20;
                1: pct = 60;
                2: pct = 95;
                3: pct = 100;
                4: pct = 50;
                default: pct = 80;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 99) < pct) begin
                    cs_n = 1'b0;
                    if ($urandom_range(0, 3) == 0) begin
                        wr_n = 1'b0; rd_n = 1'b1;
                    end else begin
                        rd_n = 1'b0; wr_n = 1'b1;
                    end
                    cpu_a = ($urandom_range(0, 1) == 1) ? 10'h010 : 10'($urandom);
                    cpu_d = 8'($urandom);
                end else begin
                    cs_n = 1'($urandom_range(0, 1));
                    rd_n = 1'b1; wr_n = 1'b1;
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                hs_req  = ~hs_req;
                hs_we   = 1'($urandom_range(0, 1));
                hs_a    = 10'($urandom);
                hs_d_in = 8'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dkong_wram_arb.md
# dkong_wram_arb

Arbiter for port A of the 1024×8 sprite work RAM (3A/4A). It shares that port between the Z80 and the hiscore save/restore engine. The CPU has priority, and the hiscore engine uses idle RAM cycles. If the hiscore engine is starved, the arbiter stretches a CPU cycle through WAIT_n so the hiscore access can complete. Port B, used by sprite DMA, is not touched.

## Interface
Parameters:
- STARVE_LIMIT, default 64: clocks a pending hiscore request may wait before the arbiter forces a slot (range 1..255).

Ports:
- I_CLK  in  1: 24.576 MHz system clock. All logic is on the rising edge.
- I_RESET  in  1: synchronous, active-high reset.
- I_CLK_EN_P  in  1: CPU phase enable, where H_CNT[1:0]==01.
- I_CPU_A  in  10: CPU address [9:0].
- I_CPU_D  in  8: CPU write data.
- I_CPU_CS_n  in  1: RAM3 chip select from the address decoder.
- I_CPU_RD_n, I_CPU_WR_n  in  1 each: CPU strobes.
- O_CPU_D  out  8: read data to the CPU bus. It is 8'h00 when the CPU is not reading, so it can be OR-merged onto the bus.
- O_CPU_WAIT_n  out  1: wait request to the CPU. It is ANDed with the decoder's WAIT_n.
- I_HS_REQ  in  1: hiscore access request, level-sensitive.
- I_HS_WE  in  1: hiscore write when 1, read when 0.
- I_HS_A  in  10: hiscore address.
- I_HS_D  in  8: hiscore write data.
- O_HS_ACK  out  1: one-clock pulse when the hiscore access completes.
- O_HS_D  out  8: hiscore read data. It is valid only while O_HS_ACK=1.
- O_RAM_A  out  10, O_RAM_D  out  8, O_RAM_CE  out  1, O_RAM_WE  out  1: RAM port A controls, driven combinationally from the owner mux.
- I_RAM_Q  in  8: RAM port A output, registered, with 1-clock read latency.

## Operation
- A CPU access (cpu_act) is defined as ~I_CPU_CS_n & (~I_CPU_RD_n | ~I_CPU_WR_n).
- The CPU write enable is ~I_CPU_WR_n.
- Owner mux per clock:
  - The HS side owns the port in the HS_ISSUE state.
  - Otherwise the CPU owns the port when cpu_act=1.
  - Otherwise the port is idle, with CE=0 and WE=0.
- FSM states:
  - IDLE
    - I_HS_REQ & ~cpu_act → HS_ISSUE.
    - I_HS_REQ & cpu_act: starve_cnt increments. When starve_cnt==STARVE_LIMIT → STEAL.
  - STEAL
    - O_CPU_WAIT_n=0.
    - On the first clock where I_CLK_EN_P=1 → HS_ISSUE. O_CPU_WAIT_n stays 0 during that clock.
  - HS_ISSUE
    - The RAM is driven from the HS inputs with CE=1 and WE=I_HS_WE → HS_ACK.
    - If entered from STEAL, O_CPU_WAIT_n stays 0.
  - HS_ACK
    - O_HS_ACK=1.
    - O_HS_D=I_RAM_Q for a read, 8'h00 for a write.
    - starve_cnt is cleared.
    - O_CPU_WAIT_n returns to 1.
    - Next state: IDLE. If I_HS_REQ is still 1 it is treated as a new request, evaluated in IDLE on the following clock.
- starve_cnt:
  - It is 8 bits wide and saturates at STARVE_LIMIT.
  - It is cleared in IDLE whenever I_HS_REQ=0.
- CPU read path:
  - rd_own is a register set when the owner was the CPU with WE=0 in the previous clock.
  - O_CPU_D = (rd_own & cpu_act & ~I_CPU_RD_n) ? I_RAM_Q : 8'h00.
- A CPU write stalled under WAIT is repeated on later cycles. Writing the same value again is harmless.
- A stalled CPU read re-reads after the HS slot.
- An HS request deasserted before O_HS_ACK:
  - In IDLE or STEAL: abandoned, with no RAM cycle and no ACK.
  - In HS_ISSUE: the access still completes and ACK still pulses.

## Timing
- Reset values:
  - state=IDLE, starve_cnt=0, rd_own=0.
  - O_CPU_WAIT_n=1, O_HS_ACK=0, O_HS_D=0, O_CPU_D=0.
  - O_RAM_CE=0, O_RAM_WE=0.
  - O_RAM_A and O_RAM_D equal I_CPU_A and I_CPU_D.
- Reset asserted mid-access aborts the HS access: no ACK is issued, and WAIT_n is released at the next edge.
- Uncontended HS latency: REQ sampled in IDLE at clock n, HS_ISSUE at n+1, ACK at n+2. A new HS access is accepted at most every 3 clocks.
- Contended HS latency is bounded by STARVE_LIMIT + 8 + 2 clocks. The phase enable occurs every 4 clocks.
- CPU read data appears 1 clock after the owning cycle.
- The CPU is never stalled more than 1 CPU T-state per HS access.
- When a new request and a CPU access arrive in the same clock, the CPU wins unless the FSM is in STEAL or HS_ISSUE.

## Test plan
- Reset: hold I_RESET for 2 clocks with I_HS_REQ=1 → O_HS_ACK=0, O_CPU_WAIT_n=1, O_RAM_CE=0. After release, the first ACK comes 2 clocks later.
- Idle HS write then read: write A=0x155 with D=0xA5 while the CPU is idle. Then read 0x155 → ACK at +2 clocks each, and O_HS_D=0xA5 on the read ACK.
- CPU priority: the CPU reads 0x010 continuously with cpu_act=1, and HS requests arrive in gaps → no HS RAM cycle overlaps a CPU cycle, and O_CPU_D always carries the correct RAM byte.
- Starvation, with STARVE_LIMIT=4 and cpu_act held at 1 → WAIT_n goes low after 4 counted clocks, HS_ISSUE follows the next I_CLK_EN_P, ACK pulses, WAIT_n returns high in the ACK clock, and the CPU read data is correct after release.
- Abandoned request: raise I_HS_REQ under contention, then drop it before STEAL → no ACK, no RAM cycle, and starve_cnt=0.
- Back-to-back: hold I_HS_REQ=1 on an idle bus for 9 clocks → ACK pulses at +2, +5 and +8.
